plant_multi_axis: RTL and testbench

PLANT_MULTI_AXIS -- requirements
Module: plant_multi_axis

---
 rtl/plant_multi_axis.sv | 128 ++++++++++++
 tb/tb_plant_multi_axis.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/plant_multi_axis.sv
// Multi-axis rate/angle plant stepped by one shared adder, one axis per cycle.
// Build option: define PLANT_SAT_EN to clamp results; otherwise they wrap.
//
// state  | meaning
// IDLE   | waiting for tick; axis states held
// UPDATE | writing axis idx from the captured inputs
// DONE   | one-cycle completion pulse, then IDLE
module plant_multi_axis #(
  parameter int NUM_AXES   = 3,
  parameter int DATA_W     = 16,
  parameter int DAMP_SHIFT = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         tick,
  input  logic [NUM_AXES*DATA_W-1:0]   control_flat,
  input  logic [NUM_AXES*DATA_W-1:0]   disturbance_flat,
  output logic [NUM_AXES*DATA_W-1:0]   angle_flat,
  output logic [NUM_AXES*DATA_W-1:0]   rate_flat,
  output logic                         busy,
  output logic                         done,
  output logic                         overrun
);

  localparam int IDX_W = (NUM_AXES > 1) ? $clog2(NUM_AXES) : 1;
  localparam int SUM_W = DATA_W + 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_AXES - 1);

  typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;

  state_t                    state;
  logic [IDX_W-1:0]          idx;
  logic signed [DATA_W-1:0]  rate_q  [NUM_AXES];
  logic signed [DATA_W-1:0]  angle_q [NUM_AXES];
  logic signed [DATA_W-1:0]  ctl_sh  [NUM_AXES];
  logic signed [DATA_W-1:0]  dist_sh [NUM_AXES];

  logic signed [SUM_W-1:0]   rate_w;
  logic signed [SUM_W-1:0]   damp_w;
  logic signed [SUM_W-1:0]   rate_sum;
  logic signed [SUM_W-1:0]   angle_sum;
  logic signed [DATA_W-1:0]  rate_nx;
  logic signed [DATA_W-1:0]  angle_nx;

  function automatic logic signed [SUM_W-1:0] sx(input logic signed [DATA_W-1:0] v);
    return {{2{v[DATA_W-1]}}, v};
  endfunction

  function automatic logic signed [DATA_W-1:0] reduce(input logic signed [SUM_W-1:0] v);
`ifdef PLANT_SAT_EN
    logic signed [SUM_W-1:0] sat_max;
    logic signed [SUM_W-1:0] sat_min;
    sat_max = {3'b000, {(DATA_W-1){1'b1}}};
    sat_min = {3'b111, {(DATA_W-1){1'b0}}};
    if (v > sat_max)      return sat_max[DATA_W-1:0];
    else if (v < sat_min) return sat_min[DATA_W-1:0];
    else                  return v[DATA_W-1:0];
`else
    return v[DATA_W-1:0];
`endif
  endfunction

  // Shared datapath: both sums use the pre-update rate of axis idx.
  always_comb begin
    rate_w = sx(rate_q[idx]);
    damp_w = '0;
    if (DAMP_SHIFT > 0) damp_w = rate_w >>> DAMP_SHIFT;
    rate_sum  = rate_w + sx(ctl_sh[idx]) + sx(dist_sh[idx]) - damp_w;
    angle_sum = sx(angle_q[idx]) + rate_w;
    rate_nx   = reduce(rate_sum);
    angle_nx  = reduce(angle_sum);
  end

  always_comb begin
    angle_flat = '0;
    rate_flat  = '0;
    for (int i = 0; i < NUM_AXES; i++) begin
      angle_flat[i*DATA_W +: DATA_W] = angle_q[i];
      rate_flat[i*DATA_W +: DATA_W]  = rate_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
      for (int i = 0; i < NUM_AXES; i++) begin
        rate_q[i]  <= '0;
        angle_q[i] <= '0;
        ctl_sh[i]  <= '0;
        dist_sh[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      if (tick && (state != IDLE)) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (tick) begin
            for (int i = 0; i < NUM_AXES; i++) begin
              ctl_sh[i]  <= control_flat[i*DATA_W +: DATA_W];
              dist_sh[i] <= disturbance_flat[i*DATA_W +: DATA_W];
            end
            idx   <= '0;
            busy  <= 1'b1;
            state <= UPDATE;
          end
        end
        UPDATE: begin
          rate_q[idx]  <= rate_nx;
          angle_q[idx] <= angle_nx;
          if (idx == LAST_IDX) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_plant_multi_axis.sv
// Scoreboard bench for plant_multi_axis: two instances (no damping, damping shift 2).
// Expected axis states come from a behavioural step model in the bench.
module tb_plant_multi_axis;
  localparam int N = 3;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick0 = 1'b0, tick1 = 1'b0;
  logic [N*W-1:0] ctl0 = '0, dist0 = '0, ctl1 = '0, dist1 = '0;
  logic [N*W-1:0] ang0, rate0, ang1, rate1;
  logic busy0, done0, ovr0, busy1, done1, ovr1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ndone0 = 0;
  int ndone1 = 0;

  typedef struct {
    int             tcyc;
    logic [N*W-1:0] r;
    logic [N*W-1:0] a;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  logic signed [W-1:0] m_rate [2][N];
  logic signed [W-1:0] m_ang  [2][N];

  plant_multi_axis #(.NUM_AXES(N), .DATA_W(W), .DAMP_SHIFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .tick(tick0), .control_flat(ctl0),
    .disturbance_flat(dist0), .angle_flat(ang0), .rate_flat(rate0),
    .busy(busy0), .done(done0), .overrun(ovr0));

  plant_multi_axis #(.NUM_AXES(N), .DATA_W(W), .DAMP_SHIFT(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .tick(tick1), .control_flat(ctl1),
    .disturbance_flat(dist1), .angle_flat(ang1), .rate_flat(rate1),
    .busy(busy1), .done(done1), .overrun(ovr1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [N*W-1:0] pk(input int x2, input int x1, input int x0);
    return {x2[W-1:0], x1[W-1:0], x0[W-1:0]};
  endfunction

  function automatic logic signed [W-1:0] red(input longint v);
`ifdef PLANT_SAT_EN
    if (v > 32767)  return 16'sh7fff;
    if (v < -32768) return 16'sh8000;
`endif
    return W'(v);
  endfunction

  function automatic logic signed [W-1:0] getr(input int d, input int i);
    return (d == 0) ? $signed(rate0[i*W +: W]) : $signed(rate1[i*W +: W]);
  endfunction

  function automatic logic signed [W-1:0] geta(input int d, input int i);
    return (d == 0) ? $signed(ang0[i*W +: W]) : $signed(ang1[i*W +: W]);
  endfunction

  task automatic zero_model();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < N; i++) begin
        m_rate[d][i] = '0;
        m_ang[d][i]  = '0;
      end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_rate0"}, longint'(rate0), 0);
    check({tag, "_ang0"},  longint'(ang0), 0);
    check({tag, "_rate1"}, longint'(rate1), 0);
    check({tag, "_ang1"},  longint'(ang1), 0);
    check({tag, "_busy"},  {busy0, busy1}, 0);
    check({tag, "_done"},  {done0, done1}, 0);
    check({tag, "_ovr"},   {ovr0, ovr1}, 0);
  endtask

  task automatic pop_check(input int d);
    exp_t e;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      check($sformatf("done_spurious_dut%0d", d), 1, 0);
      return;
    end
    e = (d == 0) ? q0.pop_front() : q1.pop_front();
    check($sformatf("done_latency_dut%0d", d), cyc, e.tcyc + N + 1);
    for (int i = 0; i < N; i++) begin
      check($sformatf("rate_dut%0d_ax%0d", d, i), getr(d, i), $signed(e.r[i*W +: W]));
      check($sformatf("angle_dut%0d_ax%0d", d, i), geta(d, i), $signed(e.a[i*W +: W]));
    end
  endtask

  always @(negedge clk) begin
    if (done0) begin ndone0++; pop_check(0); end
    if (done1) begin ndone1++; pop_check(1); end
  end

  // mode 0: plain step; 1: extra tick at T+2; 2: control changed at T+1
  task automatic step(input int d, input logic [N*W-1:0] c, input logic [N*W-1:0] s,
                      input int mode);
    exp_t e;
    logic [N*W-1:0] old_r;
    bit seen;
    int sh;
    seen = 1'b0;
    sh = (d == 1) ? 2 : 0;
    for (int i = 0; i < N; i++) begin
      logic signed [W-1:0] r, a, cc, ss;
      longint dmp;
      r  = m_rate[d][i];
      a  = m_ang[d][i];
      cc = c[i*W +: W];
      ss = s[i*W +: W];
      old_r[i*W +: W] = r;
      dmp = (sh != 0) ? longint'(r >>> sh) : 64'sd0;
      m_rate[d][i] = red(longint'(r) + longint'(cc) + longint'(ss) - dmp);
      m_ang[d][i]  = red(longint'(a) + longint'(r));
      e.r[i*W +: W] = m_rate[d][i];
      e.a[i*W +: W] = m_ang[d][i];
    end
    e.tcyc = cyc;
    if (d == 0) begin
      q0.push_back(e);
      ctl0 = c; dist0 = s; tick0 = 1'b1;
    end else begin
      q1.push_back(e);
      ctl1 = c; dist1 = s; tick1 = 1'b1;
    end
    @(posedge clk); #1;
    tick0 = 1'b0;
    tick1 = 1'b0;
    if (mode == 2) begin
      ctl0  = ~c;
      dist0 = ~s;
    end
    @(negedge clk);
    check($sformatf("busy_t1_dut%0d", d), (d == 0) ? busy0 : busy1, 1);
    if (mode == 2) begin
      @(negedge clk);
      check("axis0_visible_t2", getr(0, 0), $signed(e.r[0 +: W]));
      check("axis1_held_t2", getr(0, 1), $signed(old_r[W +: W]));
    end
    if (mode == 1) begin
      @(posedge clk); #1;
      tick0 = 1'b1;
      @(posedge clk); #1;
      tick0 = 1'b0;
    end
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clk);
      if ((d == 0) ? done0 : done1) seen = 1'b1;
    end
    if (!seen) check($sformatf("done_timeout_dut%0d", d), 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int nd;
    zero_model();
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("por");

    // first step launched on the first edge with reset released
    rst_n = 1'b1;
    step(0, pk(-7, 100, 5), pk(3, -50, -2), 0);
    check("basic_rate_1", getr(0, 0), 3);
    check("basic_ang_1", geta(0, 0), 0);
    step(0, pk(-7, 100, 5), pk(3, -50, -2), 0);
    check("basic_rate_2", getr(0, 0), 6);
    check("basic_ang_2", geta(0, 0), 3);
    step(0, pk(-7, 100, 5), pk(3, -50, -2), 0);
    check("basic_rate_3", getr(0, 0), 9);
    check("basic_ang_3", geta(0, 0), 9);

    step(1, pk(-40, 7, 100), pk(0, 0, 0), 0);
    check("damp_rate_seed", getr(1, 0), 100);
    step(1, pk(0, 0, 0), pk(0, 0, 0), 0);
    check("damp_rate_1", getr(1, 0), 75);
    step(1, pk(0, 0, 0), pk(0, 0, 0), 0);
    check("damp_rate_2", getr(1, 0), 57);
    check("ovr_clear_before", ovr0, 0);

    step(0, pk(1234, -999, 77), pk(-4, 8, 300), 2);

    nd = ndone0;
    step(0, pk(1, 2, 3), pk(0, 0, 0), 1);
    repeat (4) @(posedge clk);
    #1;
    check("overrun_single_done", ndone0 - nd, 1);
    check("overrun_set", ovr0, 1);
    step(0, pk(-5, 5, -5), pk(1, 1, 1), 0);
    check("overrun_sticky", ovr0, 1);
    check("overrun_other_dut", ovr1, 0);

    // reset lands mid-UPDATE after axis 0 has been written
    ctl0 = pk(50, 50, 50);
    tick0 = 1'b1;
    @(posedge clk); #1;
    tick0 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset_state("mid_rst");
    rst_n = 1'b1;
    zero_model();
    repeat (6) @(posedge clk);
    #1;

    step(0, pk(0, 32767, -32768), pk(0, 0, 0), 0);
    check("ovf_rate_seed", getr(0, 1), 32767);
    step(0, pk(0, 1, -1), pk(0, 0, 0), 0);
`ifdef PLANT_SAT_EN
    check("ovf_rate_pos", getr(0, 1), 32767);
    check("ovf_rate_neg", getr(0, 0), -32768);
`else
    check("ovf_rate_pos", getr(0, 1), -32768);
    check("ovf_rate_neg", getr(0, 0), 32767);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("queue_empty_dut0", q0.size(), 0);
    check("queue_empty_dut1", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
